// File: rtl/tb_video_pkg.sv
// Shared raster geometry for the video timing generator: native Tank Battalion
// raster, a VGA 640x480 alternate, and sync polarity names.
package tb_video_pkg;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int clk_div;
        int h_total;
        int h_active;
        int h_sync_start;
        int h_sync_len;
        int v_total;
        int v_active;
        int v_sync_start;
        int v_sync_len;
        bit hs_pol;
        bit vs_pol;
        int irq_line;
        int tile_w;
    } vt_geom_t;

    localparam vt_geom_t TB_GEOM = '{
        clk_div: 4, h_total: 384, h_active: 256, h_sync_start: 288, h_sync_len: 32,
        v_total: 264, v_active: 224, v_sync_start: 240, v_sync_len: 8,
        hs_pol: SYNC_ACTIVE_LOW, vs_pol: SYNC_ACTIVE_LOW, irq_line: 224, tile_w: 8};

    localparam vt_geom_t VGA_GEOM = '{
        clk_div: 1, h_total: 800, h_active: 640, h_sync_start: 656, h_sync_len: 96,
        v_total: 525, v_active: 480, v_sync_start: 490, v_sync_len: 2,
        hs_pol: SYNC_ACTIVE_LOW, vs_pol: SYNC_ACTIVE_LOW, irq_line: 480, tile_w: 8};

endpackage

// File: rtl/tb_video_timing_if.sv
// Raster timing bundle: the generator drives timing, the CPU side returns the IRQ ack.
interface tb_video_timing_if #(
    parameter int HW = 9,
    parameter int VW = 9
);
    logic          irq_ack_n;
    logic          pix_ce;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hsync;
    logic          vsync;
    logic          hblank;
    logic          vblank;
    logic          de;
    logic          tile_load;
    logic          line_start;
    logic          frame_start;
    logic          irq_n;

    modport master (
        input  irq_ack_n,
        output pix_ce, hcnt, vcnt, hsync, vsync, hblank, vblank, de,
               tile_load, line_start, frame_start, irq_n
    );

    modport slave (
        output irq_ack_n,
        input  pix_ce, hcnt, vcnt, hsync, vsync, hblank, vblank, de,
               tile_load, line_start, frame_start, irq_n
    );
endinterface

// File: rtl/tb_timing_axis.sv
// One raster axis: wrapping counter plus registered sync-window and blank decode,
// both taken from the next count so they line up with the count they describe.
module tb_timing_axis
    import tb_video_pkg::*;
#(
    parameter int TOTAL      = 384,
    parameter int ACTIVE     = 256,
    parameter int SYNC_START = 288,
    parameter int SYNC_LEN   = 32,
    parameter bit POL        = SYNC_ACTIVE_LOW,
    parameter int W          = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         sync,
    output logic         blank,
    output logic         blank_nxt
);
    // One spare bit so SYNC_START+SYNC_LEN == TOTAL still compares correctly.
    localparam int        WX   = W + 1;
    localparam logic [W-1:0]  LAST = W'(TOTAL - 1);
    localparam logic [WX-1:0] ACT  = WX'(ACTIVE);
    localparam logic [WX-1:0] SS   = WX'(SYNC_START);
    localparam logic [WX-1:0] SE   = WX'(SYNC_START + SYNC_LEN);

    logic [WX-1:0] nxt_x;
    logic          sync_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (step) cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign nxt_x     = {1'b0, cnt_nxt};
    assign blank_nxt = (nxt_x >= ACT);
    assign sync_nxt  = (nxt_x >= SS && nxt_x < SE) ? POL : ~POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sync  <= ~POL;
            blank <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            sync  <= sync_nxt;
            blank <= blank_nxt;
        end
    end
endmodule

// File: rtl/tb_video_timing.sv
// Parametrised raster timing generator: pixel divider, H/V axes, tile load strobe,
// line/frame pulses and a latched vblank IRQ with CPU acknowledge.
module tb_video_timing
    import tb_video_pkg::*;
#(
    parameter int CLK_DIV      = TB_GEOM.clk_div,
    parameter int H_TOTAL      = TB_GEOM.h_total,
    parameter int H_ACTIVE     = TB_GEOM.h_active,
    parameter int H_SYNC_START = TB_GEOM.h_sync_start,
    parameter int H_SYNC_LEN   = TB_GEOM.h_sync_len,
    parameter int V_TOTAL      = TB_GEOM.v_total,
    parameter int V_ACTIVE     = TB_GEOM.v_active,
    parameter int V_SYNC_START = TB_GEOM.v_sync_start,
    parameter int V_SYNC_LEN   = TB_GEOM.v_sync_len,
    parameter bit HS_POL       = TB_GEOM.hs_pol,
    parameter bit VS_POL       = TB_GEOM.vs_pol,
    parameter int IRQ_LINE     = TB_GEOM.irq_line,
    parameter int TILE_W       = TB_GEOM.tile_w
) (
    input logic              clk,
    input logic              rst_n,
    tb_video_timing_if.master vt
);
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] TILE_MASK = HW'(TILE_W - 1);
    localparam logic [VW-1:0] IRQ_V     = VW'(IRQ_LINE);

    if (!(H_ACTIVE <= H_SYNC_START)) begin : g_err_hact
        $error("H_ACTIVE must not exceed H_SYNC_START");
    end
    if (!(H_SYNC_START + H_SYNC_LEN <= H_TOTAL)) begin : g_err_hsync
        $error("hsync window runs past H_TOTAL");
    end
    if (!(V_ACTIVE <= V_SYNC_START)) begin : g_err_vact
        $error("V_ACTIVE must not exceed V_SYNC_START");
    end
    if (!(V_SYNC_START + V_SYNC_LEN <= V_TOTAL)) begin : g_err_vsync
        $error("vsync window runs past V_TOTAL");
    end
    if (!(IRQ_LINE < V_TOTAL)) begin : g_err_irq
        $error("IRQ_LINE must be below V_TOTAL");
    end
    if (!(CLK_DIV >= 1)) begin : g_err_div
        $error("CLK_DIV must be at least 1");
    end
    if (!(TILE_W > 0 && (TILE_W & (TILE_W - 1)) == 0 && TILE_W <= H_ACTIVE)) begin : g_err_tile
        $error("TILE_W must be a power of 2 no larger than H_ACTIVE");
    end

    logic [DW-1:0] div;
    logic          pix_ce, pix_ce_nxt, run;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;
    logic          hsync, vsync, hblank, vblank, hblank_nxt, vblank_nxt;
    logic          hwrap, irq_set;
    logic          de, tile_load, line_start, frame_start, irq_n;

    assign pix_ce_nxt = (div == DIV_MAX);
    assign hwrap      = pix_ce && (hcnt == H_LAST);
    assign irq_set    = hwrap && (vcnt_nxt == IRQ_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            pix_ce <= 1'b0;
        end else begin
            div    <= pix_ce_nxt ? '0 : div + 1'b1;
            pix_ce <= pix_ce_nxt;
        end
    end

    tb_timing_axis #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_SYNC_START),
        .SYNC_LEN(H_SYNC_LEN), .POL(HS_POL), .W(HW)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(pix_ce),
        .cnt(hcnt), .cnt_nxt(hcnt_nxt), .sync(hsync),
        .blank(hblank), .blank_nxt(hblank_nxt)
    );

    tb_timing_axis #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_SYNC_START),
        .SYNC_LEN(V_SYNC_LEN), .POL(VS_POL), .W(VW)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(hwrap),
        .cnt(vcnt), .cnt_nxt(vcnt_nxt), .sync(vsync),
        .blank(vblank), .blank_nxt(vblank_nxt)
    );

    // Strobes are registered from next-state values so they coincide with the
    // pix_ce cycle and counts they describe; de stays low until the raster starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            de          <= 1'b0;
            tile_load   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= run | pix_ce_nxt;
            de          <= (run | pix_ce_nxt) & ~hblank_nxt & ~vblank_nxt;
            tile_load   <= pix_ce_nxt && ((hcnt_nxt & TILE_MASK) == TILE_MASK);
            line_start  <= pix_ce_nxt && (hcnt_nxt == '0);
            frame_start <= pix_ce_nxt && (hcnt_nxt == '0) && (vcnt_nxt == '0);
        end
    end

    // Ack has priority so a coincident set is dropped rather than latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          irq_n <= 1'b1;
        else if (!vt.irq_ack_n) irq_n <= 1'b1;
        else if (irq_set)    irq_n <= 1'b0;
    end

    assign vt.pix_ce      = pix_ce;
    assign vt.hcnt        = hcnt;
    assign vt.vcnt        = vcnt;
    assign vt.hsync       = hsync;
    assign vt.vsync       = vsync;
    assign vt.hblank      = hblank;
    assign vt.vblank      = vblank;
    assign vt.de          = de;
    assign vt.tile_load   = tile_load;
    assign vt.line_start  = line_start;
    assign vt.frame_start = frame_start;
    assign vt.irq_n       = irq_n;
endmodule
